// File: rtl/mux_port_arbiter.sv
// Round-robin arbiter for a 2:1-muxed shared datapath port: one-hot grant,
// registered mux select, and a hold timeout that preempts a lingering owner.
module mux_port_arbiter #(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] done,
    output logic [1:0] grant,
    output logic       sel,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r;
    state_t           state_s;
    logic             prio_r;
    logic             prio_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [1:0]       grant_r;
    logic [1:0]       grant_s;
    logic             sel_r;
    logic             sel_s;
    logic             busy_r;
    logic             timeout_r;
    logic             timeout_s;

    // Next-state arbitration, hold counter, priority pointer and output decode.
    always_comb begin
        state_s   = state_r;
        prio_s    = prio_r;
        cnt_s     = cnt_r;
        sel_s     = sel_r;
        grant_s   = 2'b00;
        timeout_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (req == 2'b11) begin
                    state_s = prio_r ? ST_OWN1 : ST_OWN0;
                end else if (req == 2'b01) begin
                    state_s = ST_OWN0;
                end else if (req == 2'b10) begin
                    state_s = ST_OWN1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_OWN0: begin
                // A voluntary release takes precedence; timeout only flags a true preemption.
                if (done[0] || !req[0]) begin
                    state_s = req[1] ? ST_OWN1 : ST_IDLE;
                end else if ((cnt_r == CNT_LAST) && req[1]) begin
                    state_s   = ST_OWN1;
                    timeout_s = 1'b1;
                end else begin
                    state_s = ST_OWN0;
                end
            end
            ST_OWN1: begin
                if (done[1] || !req[1]) begin
                    state_s = req[0] ? ST_OWN0 : ST_IDLE;
                end else if ((cnt_r == CNT_LAST) && req[0]) begin
                    state_s   = ST_OWN0;
                    timeout_s = 1'b1;
                end else begin
                    state_s = ST_OWN1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Counter restarts on any ownership change and saturates while retained.
        if (state_s != state_r) begin
            cnt_s = CNT_ZERO;
        end else if ((state_r != ST_IDLE) && (cnt_r != CNT_LAST)) begin
            cnt_s = cnt_r + CNT_ONE;
        end else begin
            cnt_s = cnt_r;
        end

        if ((state_s == ST_OWN0) && (state_r != ST_OWN0)) begin
            prio_s = 1'b1;
        end else if ((state_s == ST_OWN1) && (state_r != ST_OWN1)) begin
            prio_s = 1'b0;
        end else begin
            prio_s = prio_r;
        end

        // sel keeps its last value in IDLE so the mux does not toggle while free.
        case (state_s)
            ST_OWN0: begin
                grant_s = 2'b01;
                sel_s   = 1'b0;
            end
            ST_OWN1: begin
                grant_s = 2'b10;
                sel_s   = 1'b1;
            end
            default: begin
                grant_s = 2'b00;
                sel_s   = sel_r;
            end
        endcase
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            prio_r    <= 1'b0;
            cnt_r     <= CNT_ZERO;
            grant_r   <= 2'b00;
            sel_r     <= 1'b0;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            prio_r    <= prio_s;
            cnt_r     <= cnt_s;
            grant_r   <= grant_s;
            sel_r     <= sel_s;
            busy_r    <= |grant_s;
            timeout_r <= timeout_s;
        end
    end

    assign grant   = grant_r;
    assign sel     = sel_r;
    assign busy    = busy_r;
    assign timeout = timeout_r;

endmodule

// File: tb/tb_mux_port_arbiter.sv
// Directed scoreboard bench for mux_port_arbiter: each step queues the expected
// registered outputs and checks them one edge later.
module tb_mux_port_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [1:0] done;
    logic [1:0] grant;
    logic       sel;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [1:0] grant;
        logic       sel;
        logic       timeout;
    } exp_t;

    exp_t sb_q[$];

    mux_port_arbiter #(.HOLD_MAX(4), .CNT_W(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic rst, input logic [1:0] rq, input logic [1:0] dn,
                        input logic [1:0] eg, input logic es, input logic et,
                        input string tag);
        exp_t e;
        exp_t got;
        reset = rst;
        req   = rq;
        done  = dn;
        e.tag = tag;
        e.grant = eg;
        e.sel = es;
        e.timeout = et;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        checks++;
        assert (grant === got.grant) else begin
            errors++;
            $error("FAIL %s grant: observed %b expected %b", got.tag, grant, got.grant);
        end
        checks++;
        assert (sel === got.sel) else begin
            errors++;
            $error("FAIL %s sel: observed %b expected %b", got.tag, sel, got.sel);
        end
        checks++;
        assert (busy === (got.grant != 2'b00)) else begin
            errors++;
            $error("FAIL %s busy: observed %b expected %b", got.tag, busy, (got.grant != 2'b00));
        end
        checks++;
        assert (timeout === got.timeout) else begin
            errors++;
            $error("FAIL %s timeout: observed %b expected %b", got.tag, timeout, got.timeout);
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = 2'b00;
        done  = 2'b00;

        // 1: reset dominates requests, then requester 0 wins the first tie
        for (int i = 0; i < 3; i++) step(1'b1, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, "t1_reset");
        step(1'b0, 2'b11, 2'b00, 2'b01, 1'b0, 1'b0, "t1_first_tie");
        step(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, "t1_release");

        // 2: done[0] with req=10 hands over without an idle bubble
        step(1'b0, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, "t2_grant0");
        step(1'b0, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, "t2_hold0a");
        step(1'b0, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, "t2_hold0b");
        step(1'b0, 2'b10, 2'b01, 2'b10, 1'b1, 1'b0, "t2_handover");
        step(1'b0, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0, "t2_hold1");
        step(1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, "t2_idle_sel_hold");
        step(1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, "t2_idle_sel_hold2");

        // 3: both requesting, hold timeout alternates the owner every 4 cycles
        step(1'b0, 2'b11, 2'b00, 2'b01, 1'b0, 1'b0, "t3_own0_c0");
        for (int i = 0; i < 3; i++) step(1'b0, 2'b11, 2'b00, 2'b01, 1'b0, 1'b0, "t3_own0_hold");
        step(1'b0, 2'b11, 2'b00, 2'b10, 1'b1, 1'b1, "t3_timeout_to1");
        for (int i = 0; i < 3; i++) step(1'b0, 2'b11, 2'b00, 2'b10, 1'b1, 1'b0, "t3_own1_hold");
        step(1'b0, 2'b11, 2'b00, 2'b01, 1'b0, 1'b1, "t3_timeout_to0");
        step(1'b0, 2'b11, 2'b00, 2'b01, 1'b0, 1'b0, "t3_own0_again");
        step(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, "t3_idle");

        // 4: lone requester keeps the port indefinitely, no timeout
        for (int i = 0; i < 20; i++) step(1'b0, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, "t4_lone_owner");
        step(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, "t4_idle");

        // 5: reset while owning drops grant at once and clears prio
        step(1'b0, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0, "t5_own1");
        step(1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, "t5_reset_own1");
        step(1'b0, 2'b11, 2'b00, 2'b01, 1'b0, 1'b0, "t5_tie_after_reset");
        step(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, "t5_idle");
        step(1'b0, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, "t5_own0_prio1");
        step(1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, "t5_reset_own0");
        step(1'b0, 2'b11, 2'b00, 2'b01, 1'b0, 1'b0, "t5_prio_cleared");

        // 6: non-owner done ignored; owner done with req still high releases
        step(1'b0, 2'b01, 2'b10, 2'b01, 1'b0, 1'b0, "t6_nonowner_done");
        step(1'b0, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, "t6_still_own0");
        step(1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, "t6_done_req_high");
        step(1'b0, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, "t6_rearbitrate");
        step(1'b0, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0, "t6_req_drop_handover");
        for (int i = 0; i < 5; i++) step(1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, "t6_idle_hold");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
